// File: rtl/immediate_encoder.sv
// immediate_encoder
//   Inserts an immediate into the immediate bit positions of a base
//   instruction word. Five formats are supported: U, J, I, S and B.
//   Encoded results are queued in a 2-entry in-order FIFO with a
//   valid/ready handshake on both sides.
//
// Ports
//   i_Clock            sole clock, rising edge
//   i_Reset            synchronous, active-high reset
//   i_Valid / o_Ready  upstream handshake; o_Ready depends on registers only
//   i_Imm_Select       0=U 1=J 2=I 3=S 4=B; 5..7 are unknown and flagged
//   i_Immediate        two's-complement immediate
//   i_Instruction_Base opcode/register/funct fields; its immediate bits are ignored
//   o_Valid / i_Ready  downstream handshake
//   o_Instruction      encoded instruction at the FIFO head
//   o_Error            error flag travelling with o_Instruction
//   o_Error_Count      saturating count of accepted flagged requests
//
// Build option
//   IMM_ENCODER_RANGE_CHECK_EN  also flags immediates that do not fit the
//                               selected format (or are misaligned for B/J).

module immediate_encoder #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_Clock,
  input  logic            i_Reset,
  input  logic            i_Valid,
  output logic            o_Ready,
  input  logic [2:0]      i_Imm_Select,
  input  logic [XLEN-1:0] i_Immediate,
  input  logic [XLEN-1:0] i_Instruction_Base,
  output logic            o_Valid,
  input  logic            i_Ready,
  output logic [XLEN-1:0] o_Instruction,
  output logic            o_Error,
  output logic [7:0]      o_Error_Count
);

  typedef enum logic [2:0] {
    FMT_U = 3'd0,
    FMT_J = 3'd1,
    FMT_I = 3'd2,
    FMT_S = 3'd3,
    FMT_B = 3'd4
  } imm_fmt_e;

  logic [XLEN-1:0] enc_inst;
  logic            enc_err;
  logic            sel_unknown;
  logic            range_err;

  always_comb begin
    enc_inst    = i_Instruction_Base;
    sel_unknown = 1'b0;
    case (i_Imm_Select)
      FMT_U: enc_inst[31:12] = i_Immediate[31:12];
      FMT_J: begin
        enc_inst[31]    = i_Immediate[20];
        enc_inst[30:21] = i_Immediate[10:1];
        enc_inst[20]    = i_Immediate[11];
        enc_inst[19:12] = i_Immediate[19:12];
      end
      FMT_I: enc_inst[31:20] = i_Immediate[11:0];
      FMT_S: begin
        enc_inst[31:25] = i_Immediate[11:5];
        enc_inst[11:7]  = i_Immediate[4:0];
      end
      FMT_B: begin
        enc_inst[31]    = i_Immediate[12];
        enc_inst[30:25] = i_Immediate[10:5];
        enc_inst[11:8]  = i_Immediate[4:1];
        enc_inst[7]     = i_Immediate[11];
      end
      default: sel_unknown = 1'b1;
    endcase
  end

`ifdef IMM_ENCODER_RANGE_CHECK_EN
  // An immediate fits an N-bit signed field when it equals the sign
  // extension of its own low N bits.
  logic fits12, fits13, fits21;
  assign fits12 = (i_Immediate == {{(XLEN-12){i_Immediate[11]}}, i_Immediate[11:0]});
  assign fits13 = (i_Immediate == {{(XLEN-13){i_Immediate[12]}}, i_Immediate[12:0]});
  assign fits21 = (i_Immediate == {{(XLEN-21){i_Immediate[20]}}, i_Immediate[20:0]});

  always_comb begin
    range_err = 1'b0;
    case (i_Imm_Select)
      FMT_U:        range_err = (i_Immediate[11:0] != 12'd0);
      FMT_J:        range_err = !fits21 || i_Immediate[0];
      FMT_I, FMT_S: range_err = !fits12;
      FMT_B:        range_err = !fits13 || i_Immediate[0];
      default:      range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  assign enc_err = sel_unknown || range_err;

  // Two-entry FIFO kept as head/tail registers; the head drives the outputs.
  logic [1:0]      occ;
  logic [XLEN-1:0] head_inst, tail_inst;
  logic            head_err, tail_err;
  logic            push, pop;

  assign o_Ready       = (occ < 2'd2);
  assign o_Valid       = (occ != 2'd0);
  assign o_Instruction = head_inst;
  assign o_Error       = head_err;

  assign push = i_Valid && o_Ready;
  assign pop  = o_Valid && i_Ready;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      occ           <= '0;
      head_inst     <= '0;
      head_err      <= 1'b0;
      tail_inst     <= '0;
      tail_err      <= 1'b0;
      o_Error_Count <= '0;
    end else begin
      if (push && !pop) begin
        if (occ == 2'd0) begin
          head_inst <= enc_inst;
          head_err  <= enc_err;
        end else begin
          tail_inst <= enc_inst;
          tail_err  <= enc_err;
        end
        occ <= occ + 2'd1;
      end else if (pop && !push) begin
        head_inst <= tail_inst;
        head_err  <= tail_err;
        occ       <= occ - 2'd1;
      end else if (push && pop) begin
        // Occupancy stays put: with one entry the new one becomes the head;
        // with two, the tail advances and the new one takes its place.
        if (occ == 2'd1) begin
          head_inst <= enc_inst;
          head_err  <= enc_err;
        end else begin
          head_inst <= tail_inst;
          head_err  <= tail_err;
          tail_inst <= enc_inst;
          tail_err  <= enc_err;
        end
      end

      if (push && enc_err && (o_Error_Count != 8'hFF))
        o_Error_Count <= o_Error_Count + 8'd1;
    end
  end

endmodule

// File: tb/tb_immediate_encoder.sv
// Directed self-checking bench for immediate_encoder.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_immediate_encoder;

  logic        i_Clock = 1'b0;
  logic        i_Reset;
  logic        i_Valid;
  logic        o_Ready;
  logic [2:0]  i_Imm_Select;
  logic [31:0] i_Immediate;
  logic [31:0] i_Instruction_Base;
  logic        o_Valid;
  logic        i_Ready;
  logic [31:0] o_Instruction;
  logic        o_Error;
  logic [7:0]  o_Error_Count;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned exp_cnt = 0;

  always #5 i_Clock = ~i_Clock;

  immediate_encoder #(.XLEN(32)) dut (
    .i_Clock            (i_Clock),
    .i_Reset            (i_Reset),
    .i_Valid            (i_Valid),
    .o_Ready            (o_Ready),
    .i_Imm_Select       (i_Imm_Select),
    .i_Immediate        (i_Immediate),
    .i_Instruction_Base (i_Instruction_Base),
    .o_Valid            (o_Valid),
    .i_Ready            (i_Ready),
    .o_Instruction      (o_Instruction),
    .o_Error            (o_Error),
    .o_Error_Count      (o_Error_Count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] sel, input logic [31:0] imm, input logic [31:0] base);
    i_Valid            = 1'b1;
    i_Imm_Select       = sel;
    i_Immediate        = imm;
    i_Instruction_Base = base;
  endtask

  // One request into an empty FIFO with i_Ready high; result checked one
  // cycle after acceptance.
  task automatic run_one(input string tag, input logic [2:0] sel, input logic [31:0] imm,
                         input logic [31:0] base, input logic [31:0] exp_inst, input logic exp_err);
    @(negedge i_Clock);
    check({tag, "_rdy"}, {31'd0, o_Ready}, 32'd1);
    drive(sel, imm, base);
    @(negedge i_Clock);
    i_Valid = 1'b0;
    if (exp_err) exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
    check({tag, "_vld"}, {31'd0, o_Valid}, 32'd1);
    check({tag, "_inst"}, o_Instruction, exp_inst);
    check({tag, "_err"}, {31'd0, o_Error}, {31'd0, exp_err});
    check({tag, "_cnt"}, {24'd0, o_Error_Count}, exp_cnt);
  endtask

  task automatic do_reset();
    @(negedge i_Clock);
    i_Reset = 1'b1;
    @(negedge i_Clock);
    i_Reset = 1'b0;
    exp_cnt = 0;
  endtask

  logic range_on;

  initial begin
`ifdef IMM_ENCODER_RANGE_CHECK_EN
    range_on = 1'b1;
`else
    range_on = 1'b0;
`endif
    i_Reset = 1'b1; i_Valid = 1'b0; i_Ready = 1'b1;
    i_Imm_Select = '0; i_Immediate = '0; i_Instruction_Base = '0;
    repeat (2) @(negedge i_Clock);
    check("rst_vld", {31'd0, o_Valid}, 32'd0);
    check("rst_rdy", {31'd0, o_Ready}, 32'd1);
    check("rst_inst", o_Instruction, 32'd0);
    check("rst_err", {31'd0, o_Error}, 32'd0);
    check("rst_cnt", {24'd0, o_Error_Count}, 32'd0);
    i_Reset = 1'b0;

    // Out-of-range I immediate: flagged only with range checking built in.
    run_one("i_range", 3'd2, 32'h0000_0800, 32'h0000_0093, 32'h8000_0093, range_on);
    run_one("i_neg1",  3'd2, 32'hFFFF_FFFF, 32'h0000_0093, 32'hFFF0_0093, 1'b0);
    run_one("s_8",     3'd3, 32'h0000_0008, 32'h0020_A023, 32'h0020_A423, 1'b0);
    run_one("b_m4",    3'd4, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0);
    run_one("j_800",   3'd1, 32'h0000_0800, 32'h0000_00EF, 32'h0010_00EF, 1'b0);
    run_one("u_ok",    3'd0, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0);
    run_one("u_low",   3'd0, 32'h1234_5678, 32'h0000_0037, 32'h1234_5037, range_on);
    // Base immediate bits are overwritten; other bits pass through.
    run_one("i_base",  3'd2, 32'h0000_0005, 32'hFFFF_FFFF, 32'h005F_FFFF, 1'b0);
    run_one("unk6",    3'd6, 32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_5678, 1'b1);
    run_one("unk5",    3'd5, 32'h0000_0000, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1);

    // Backpressure: three back-to-back requests with i_Ready low.
    do_reset();
    i_Ready = 1'b0;
    @(negedge i_Clock);
    drive(3'd2, 32'd1, 32'h0000_0013);                  // A -> 0x00100013
    @(negedge i_Clock);
    check("bp_rdy1", {31'd0, o_Ready}, 32'd1);
    drive(3'd2, 32'd2, 32'h0000_0013);                  // B -> 0x00200013
    @(negedge i_Clock);
    check("bp_rdy2", {31'd0, o_Ready}, 32'd0);
    check("bp_headA", o_Instruction, 32'h0010_0013);
    drive(3'd2, 32'd3, 32'h0000_0013);                  // C -> 0x00300013
    @(negedge i_Clock);
    check("bp_hold_rdy", {31'd0, o_Ready}, 32'd0);
    check("bp_hold_A", o_Instruction, 32'h0010_0013);
    i_Ready = 1'b1;
    @(negedge i_Clock);
    check("bp_headB", o_Instruction, 32'h0020_0013);
    check("bp_rdy3", {31'd0, o_Ready}, 32'd1);
    @(negedge i_Clock);
    i_Valid = 1'b0;
    check("bp_headC", o_Instruction, 32'h0030_0013);
    check("bp_vldC", {31'd0, o_Valid}, 32'd1);
    @(negedge i_Clock);
    check("bp_empty", {31'd0, o_Valid}, 32'd0);

    // Reset with two flagged entries buffered and a request pending.
    i_Ready = 1'b0;
    @(negedge i_Clock);
    drive(3'd7, 32'd0, 32'h1111_1111);
    @(negedge i_Clock);
    drive(3'd7, 32'd0, 32'h2222_2222);
    @(negedge i_Clock);
    check("mr_cnt2", {24'd0, o_Error_Count}, 32'd2);
    drive(3'd2, 32'd7, 32'h3333_3333);
    i_Reset = 1'b1;
    @(negedge i_Clock);
    i_Reset = 1'b0;
    i_Valid = 1'b0;
    check("mr_vld", {31'd0, o_Valid}, 32'd0);
    check("mr_rdy", {31'd0, o_Ready}, 32'd1);
    check("mr_cnt", {24'd0, o_Error_Count}, 32'd0);
    i_Ready = 1'b1;
    repeat (3) @(negedge i_Clock);
    check("mr_nostale", {31'd0, o_Valid}, 32'd0);

    // Saturation: 300 unknown-select requests streamed at full rate.
    begin
      int unsigned acc = 0;
      int unsigned cyc = 0;
      while (acc < 300 && cyc < 400) begin
        @(negedge i_Clock);
        if (acc == 100) check("sat_100", {24'd0, o_Error_Count}, 32'd100);
        if (acc == 255) check("sat_255a", {24'd0, o_Error_Count}, 32'd255);
        drive(3'(5 + acc % 3), acc, 32'h1234_5678);
        if (o_Ready) acc++;
        cyc++;
      end
      check("sat_accepts", acc, 32'd300);
      @(negedge i_Clock);
      i_Valid = 1'b0;
      check("sat_last_inst", o_Instruction, 32'h1234_5678);
      check("sat_last_err", {31'd0, o_Error}, 32'd1);
      check("sat_final", {24'd0, o_Error_Count}, 32'd255);
      repeat (2) @(negedge i_Clock);
      check("sat_drained", {31'd0, o_Valid}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
